// File: rtl/ac_bank_arbiter_pkg.sv
// Shared types for the ac bank arbiter: operation codes, arbiter states and
// the mapping from a requester operation to the ac cell input pair.
package ac_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  // Returns {a,c}; 11 is the only pair that leaves a cell untouched.
  function automatic logic [1:0] op_to_ac(input op_t op);
    logic [1:0] ac;
    ac = 2'b11;
    case (op)
      OP_HOLD:   ac = 2'b11;
      OP_SET:    ac = 2'b00;
      OP_CLEAR:  ac = 2'b01;
      OP_TOGGLE: ac = 2'b10;
      default:   ac = 2'b11;
    endcase
    return ac;
  endfunction

endpackage

// File: rtl/ac_cell_bank.sv
// Bank of WIDTH ac flip-flops: 00 set, 01 clear, 10 toggle, 11 hold.
// Cells clear asynchronously on rst.
module ac_cell_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_bus,
  input  logic [WIDTH-1:0] c_bus,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({a_bus[i], c_bus[i]})
          2'b00:   q[i] <= 1'b1;
          2'b01:   q[i] <= 1'b0;
          2'b10:   q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/ac_bank_arbiter.sv
// Round-robin arbiter sharing one ac cell bank between two requesters, with
// an optional lock that holds ownership for a burst bounded by MAX_LOCK.
module ac_bank_arbiter
  import ac_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] mask0,
  input  logic             lock0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask1,
  input  logic             lock1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] a_bus,
  output logic [WIDTH-1:0] c_bus,
  output logic [WIDTH-1:0] q,
  output logic             locked
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state;
  logic             last;
  logic [CNT_W-1:0] lock_cnt;
  logic             timeout;

  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [1:0]       sel_ac;

  // Grants are gated by rst so the bank sees a clean hold while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          gnt0 = req0 & (~req1 | last);
          gnt1 = req1 & (~req0 | ~last);
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_op   = gnt1 ? op1 : op0;
    sel_mask = gnt0 ? mask0 : (gnt1 ? mask1 : '0);
    sel_ac   = op_to_ac(op_t'(sel_op));
    a_bus    = '1;
    c_bus    = '1;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_mask[i]) begin
        a_bus[i] = sel_ac[1];
        c_bus[i] = sel_ac[0];
      end
    end
  end

  assign timeout = (lock_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0) begin
            last <= 1'b0;
            if (lock0) begin
              state    <= OWN0;
              lock_cnt <= CNT_ONE;
              locked   <= 1'b1;
            end
          end else if (gnt1) begin
            last <= 1'b1;
            if (lock1) begin
              state    <= OWN1;
              lock_cnt <= CNT_ONE;
              locked   <= 1'b1;
            end
          end
        end
        OWN0: begin
          // A timed-out owner is recorded as last so the other side wins next.
          if (gnt0 || timeout) last <= 1'b0;
          if (!lock0 || timeout) begin
            state    <= IDLE;
            lock_cnt <= '0;
            locked   <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + CNT_ONE;
          end
        end
        OWN1: begin
          if (gnt1 || timeout) last <= 1'b1;
          if (!lock1 || timeout) begin
            state    <= IDLE;
            lock_cnt <= '0;
            locked   <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

  ac_cell_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .a_bus(a_bus),
    .c_bus(c_bus),
    .q    (q)
  );

endmodule

// File: tb/tb_ac_bank_arbiter.sv
// Scoreboard bench for ac_bank_arbiter: the driver pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_ac_bank_arbiter;

  localparam int WIDTH = 4;
  localparam logic [1:0] HOLD = 2'b00, SET = 2'b01, CLR = 2'b10, TOG = 2'b11;

  logic clk;
  logic rst;
  logic req0, lock0, req1, lock1;
  logic [1:0] op0, op1;
  logic [WIDTH-1:0] mask0, mask1;
  logic gnt0, gnt1, locked;
  logic [WIDTH-1:0] a_bus, c_bus, q;

  typedef struct {
    logic       g0;
    logic       g1;
    logic [3:0] q;
    logic       lk;
    logic       ac_idle;
    string      name;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  ac_bank_arbiter #(.WIDTH(WIDTH), .MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .mask0(mask0), .lock0(lock0),
    .req1(req1), .op1(op1), .mask1(mask1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .a_bus(a_bus), .c_bus(c_bus),
    .q(q), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input string field,
                              input logic [3:0] act, input logic [3:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%b required=%b", nm, field, act, req);
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "gnt0", {3'b0, gnt0}, {3'b0, e.g0});
      chk(e.name, "gnt1", {3'b0, gnt1}, {3'b0, e.g1});
      chk(e.name, "q", q, e.q);
      chk(e.name, "locked", {3'b0, locked}, {3'b0, e.lk});
      if (e.ac_idle) begin
        chk(e.name, "a_bus", a_bus, 4'b1111);
        chk(e.name, "c_bus", c_bus, 4'b1111);
      end
    end
  end

  // One bus cycle: drive inputs just after the edge, expectation holds until next edge.
  task automatic step(input logic rs,
                      input logic r0, input logic [1:0] o0, input logic [3:0] m0, input logic l0,
                      input logic r1, input logic [1:0] o1, input logic [3:0] m1, input logic l1,
                      input logic eg0, input logic eg1, input logic [3:0] eq, input logic elk,
                      input logic eac, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rs;
    req0 = r0; op0 = o0; mask0 = m0; lock0 = l0;
    req1 = r1; op1 = o1; mask1 = m1; lock1 = l1;
    e.g0 = eg0; e.g1 = eg1; e.q = eq; e.lk = elk; e.ac_idle = eac; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; op0 = HOLD; mask0 = 0; lock0 = 0;
    req1 = 0; op1 = HOLD; mask1 = 0; lock1 = 0;

    // reset held with both requesting: no grant, bank idle
    step(1, 1, SET, 4'b1111, 0, 1, SET, 4'b1111, 0, 0, 0, 4'b0000, 0, 1, "reset");
    // first grant after reset goes to requester 0
    step(0, 1, SET, 4'b0101, 0, 0, HOLD, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, "set0101");
    // round robin: 1, 0, 1
    step(0, 1, TOG, 4'b1111, 0, 1, CLR, 4'b0001, 0, 0, 1, 4'b0101, 0, 0, "rr1");
    step(0, 1, TOG, 4'b1111, 0, 1, CLR, 4'b0001, 0, 1, 0, 4'b0100, 0, 0, "rr2");
    step(0, 1, TOG, 4'b1111, 0, 1, CLR, 4'b0001, 0, 0, 1, 4'b1011, 0, 0, "rr3");
    // locked burst by requester 0 while requester 1 keeps asking
    step(0, 1, TOG, 4'b0001, 1, 1, CLR, 4'b0001, 0, 1, 0, 4'b1010, 0, 0, "lock1");
    step(0, 1, TOG, 4'b0001, 1, 1, CLR, 4'b0001, 0, 1, 0, 4'b1011, 1, 0, "lock2");
    step(0, 1, TOG, 4'b0001, 1, 1, CLR, 4'b0001, 0, 1, 0, 4'b1010, 1, 0, "lock3");
    // lock dropped without a request: no grant, back to IDLE
    step(0, 0, HOLD, 4'b0000, 0, 1, CLR, 4'b0001, 0, 0, 0, 4'b1011, 1, 1, "unlock");
    step(0, 0, HOLD, 4'b0000, 0, 1, CLR, 4'b0001, 0, 0, 1, 4'b1011, 0, 0, "after_unlock");
    // timeout: entry grant, then MAX_LOCK owned cycles, then requester 1
    step(0, 1, HOLD, 4'b1111, 1, 1, HOLD, 4'b1111, 0, 1, 0, 4'b1010, 0, 0, "to_entry");
    for (int k = 0; k < 8; k++)
      step(0, 1, HOLD, 4'b1111, 1, 1, HOLD, 4'b1111, 0, 1, 0, 4'b1010, 1, 0, "to_owned");
    step(0, 1, HOLD, 4'b1111, 1, 1, HOLD, 4'b1111, 0, 0, 1, 4'b1010, 0, 0, "to_release");
    // HOLD and empty mask: grants happen, bank untouched
    step(0, 1, HOLD, 4'b1111, 0, 0, HOLD, 4'b0000, 0, 1, 0, 4'b1010, 0, 1, "hold");
    step(0, 1, SET, 4'b0000, 0, 0, HOLD, 4'b0000, 0, 1, 0, 4'b1010, 0, 1, "mask0");
    step(0, 0, HOLD, 4'b0000, 0, 0, HOLD, 4'b0000, 0, 0, 0, 4'b1010, 0, 1, "quiet");
    // requester 1 locks with q set to all ones
    step(0, 0, HOLD, 4'b0000, 0, 1, SET, 4'b1111, 1, 0, 1, 4'b1010, 0, 0, "own1_entry");
    step(0, 1, SET, 4'b1111, 0, 1, HOLD, 4'b1111, 1, 0, 1, 4'b1111, 1, 0, "own1_hold");
    // asynchronous reset between edges mid-lock
    step(1, 1, SET, 4'b1111, 0, 1, HOLD, 4'b1111, 1, 0, 0, 4'b0000, 0, 1, "mid_reset");
    step(0, 1, SET, 4'b0011, 0, 1, SET, 4'b1100, 0, 1, 0, 4'b0000, 0, 0, "post_reset");
    step(0, 0, HOLD, 4'b0000, 0, 0, HOLD, 4'b0000, 0, 0, 0, 4'b0011, 0, 1, "post_reset_q");

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
